// File: rtl/tgl_hs_pkg.sv
// Shared definitions for the toggle (two-phase) handshake initiator/responder pair.
package tgl_hs_pkg;

    typedef enum logic [0:0] {
        TH_IDLE  = 1'b0,
        TH_VALID = 1'b1
    } th_state_e;

    // Legal range for the request synchronizer depth
    localparam int SYNC_STAGES_MIN = 1;
    localparam int SYNC_STAGES_MAX = 4;

endpackage : tgl_hs_pkg

// File: rtl/tgl_hs_responder_if.sv
// Toggle-request / valid-ready bundle seen by the responder (slave) and its environment (master).
interface tgl_hs_responder_if #(
    parameter int DW = 8,
    parameter int CW = 16
) ();
    logic          req_tgl;
    logic [DW-1:0] req_data;
    logic          ack_tgl;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          proto_err;
    logic [CW-1:0] xfer_count;

    modport slave (
        input  req_tgl, req_data, out_ready,
        output ack_tgl, out_valid, out_data, busy, proto_err, xfer_count
    );

    modport master (
        output req_tgl, req_data, out_ready,
        input  ack_tgl, out_valid, out_data, busy, proto_err, xfer_count
    );
endinterface : tgl_hs_responder_if

// File: rtl/tgl_sync.sv
// N-stage shift synchronizer with synchronous active-high reset; q is d delayed by N clocks.
module tgl_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] sync_r;

    // Shift chain, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {N{1'b0}};
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < N; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[N-1];
endmodule : tgl_sync

// File: rtl/tgl_hs_responder.sv
// Responder end of a toggle handshake: captures one word per req_tgl change, offers it on
// valid/ready, and toggles ack_tgl when the word is consumed. Flags toggles that arrive while busy.
module tgl_hs_responder
    import tgl_hs_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16
) (
    input  logic                clk,
    input  logic                rst,
    tgl_hs_responder_if.slave   hs
);
    th_state_e     state_r, state_nxt_s;
    logic          req_s;
    logic          event_s;
    logic          req_last_r, req_last_nxt_s;
    logic [DW-1:0] data_r, data_nxt_s;
    logic          ack_r, ack_nxt_s;
    logic          err_r, err_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;

    tgl_sync #(.N(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (hs.req_tgl),
        .q   (req_s)
    );

    assign event_s = (req_s != req_last_r);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= TH_IDLE;
            req_last_r <= 1'b0;
            data_r     <= {DW{1'b0}};
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            req_last_r <= req_last_nxt_s;
            data_r     <= data_nxt_s;
            ack_r      <= ack_nxt_s;
            err_r      <= err_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt_s    = state_r;
        req_last_nxt_s = req_last_r;
        data_nxt_s     = data_r;
        ack_nxt_s      = ack_r;
        err_nxt_s      = err_r;
        cnt_nxt_s      = cnt_r;
        case (state_r)
            TH_IDLE: begin
                if (event_s) begin
                    data_nxt_s     = hs.req_data;
                    req_last_nxt_s = req_s;
                    state_nxt_s    = TH_VALID;
                end else begin
                    state_nxt_s    = TH_IDLE;
                end
            end
            TH_VALID: begin
                // out_valid is high throughout VALID, so ready alone completes the handshake
                if (hs.out_ready) begin
                    ack_nxt_s   = ~ack_r;
                    cnt_nxt_s   = cnt_r + CW'(1);
                    state_nxt_s = TH_IDLE;
                end else begin
                    state_nxt_s = TH_VALID;
                end
                // A toggle while a word is pending is consumed and dropped, never captured
                if (event_s) begin
                    err_nxt_s      = 1'b1;
                    req_last_nxt_s = req_s;
                end else begin
                    err_nxt_s      = err_r;
                end
            end
            default: begin
                state_nxt_s = TH_IDLE;
            end
        endcase
    end

    assign hs.ack_tgl    = ack_r;
    assign hs.out_valid  = (state_r == TH_VALID);
    assign hs.busy       = (state_r == TH_VALID);
    assign hs.out_data   = data_r;
    assign hs.proto_err  = err_r;
    assign hs.xfer_count = cnt_r;
endmodule : tgl_hs_responder

// File: tb/tb_tgl_hs_responder.sv
// Directed bench for tgl_hs_responder; a second CW=2 instance sees the same traffic for wrap checks.
module tb_tgl_hs_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       out_ready;
    int         checks = 0;
    int         errors = 0;

    tgl_hs_responder_if #(.DW(8), .CW(16)) hs_a ();
    tgl_hs_responder_if #(.DW(8), .CW(2))  hs_b ();

    assign hs_a.req_tgl   = req_tgl;
    assign hs_a.req_data  = req_data;
    assign hs_a.out_ready = out_ready;
    assign hs_b.req_tgl   = req_tgl;
    assign hs_b.req_data  = req_data;
    assign hs_b.out_ready = out_ready;

    tgl_hs_responder #(.DW(8), .SYNC_STAGES(2), .CW(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .hs  (hs_a)
    );

    tgl_hs_responder #(.DW(8), .SYNC_STAGES(2), .CW(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .hs  (hs_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lvl);
        rst       = 1'b1;
        req_tgl   = lvl;
        out_ready = 1'b1;
        repeat (3) tick();
        rst       = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!hs_a.out_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(hs_a.out_valid), 32'd1);
    endtask

    initial begin
        // Reset with the request already high
        rst       = 1'b1;
        req_tgl   = 1'b1;
        req_data  = 8'h5A;
        out_ready = 1'b1;
        tick();
        check_eq("rst_valid", 32'(hs_a.out_valid), 32'd0);
        check_eq("rst_ack",   32'(hs_a.ack_tgl),   32'd0);
        check_eq("rst_data",  32'(hs_a.out_data),  32'h0);
        check_eq("rst_busy",  32'(hs_a.busy),      32'd0);
        check_eq("rst_err",   32'(hs_a.proto_err), 32'd0);
        check_eq("rst_cnt",   32'(hs_a.xfer_count), 32'd0);
        check_eq("rst_b_err", 32'(hs_b.proto_err | hs_b.busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rel_valid_early", 32'(hs_a.out_valid), 32'd0);
        tick();
        check_eq("rel_valid", 32'(hs_a.out_valid), 32'd1);
        check_eq("rel_data",  32'(hs_a.out_data),  32'h5A);
        tick();
        check_eq("rel_ack",   32'(hs_a.ack_tgl),   32'd1);
        check_eq("rel_cnt",   32'(hs_a.xfer_count), 32'd1);

        // Single word, 0->1 toggle
        do_reset(1'b0);
        req_data = 8'hA5;
        req_tgl  = 1'b1;
        tick();
        tick();
        check_eq("sw_valid_early", 32'(hs_a.out_valid), 32'd0);
        tick();
        check_eq("sw_valid", 32'(hs_a.out_valid), 32'd1);
        check_eq("sw_data",  32'(hs_a.out_data),  32'hA5);
        check_eq("sw_busy",  32'(hs_a.busy),      32'd1);
        tick();
        check_eq("sw_ack",   32'(hs_a.ack_tgl),   32'd1);
        check_eq("sw_vfall", 32'(hs_a.out_valid), 32'd0);
        check_eq("sw_cnt",   32'(hs_a.xfer_count), 32'd1);

        // Backpressure
        out_ready = 1'b0;
        req_data  = 8'h3C;
        req_tgl   = 1'b0;
        repeat (3) tick();
        check_eq("bp_valid", 32'(hs_a.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_valid", 32'(hs_a.out_valid), 32'd1);
            check_eq("bp_hold_data",  32'(hs_a.out_data),  32'h3C);
            check_eq("bp_hold_ack",   32'(hs_a.ack_tgl),   32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_ack",   32'(hs_a.ack_tgl),    32'd0);
        check_eq("bp_vfall", 32'(hs_a.out_valid),  32'd0);
        check_eq("bp_cnt",   32'(hs_a.xfer_count), 32'd2);
        req_data = 8'hFF;
        repeat (3) tick();
        check_eq("bp_data_kept", 32'(hs_a.out_data), 32'h3C);
        check_eq("bp_no_word",   32'(hs_a.out_valid), 32'd0);

        // Back-to-back words, then a fifth to wrap the CW=2 counter
        do_reset(1'b0);
        for (int k = 1; k <= 4; k++) begin
            req_data = 8'(k);
            req_tgl  = ~req_tgl;
            wait_valid("b2b_valid");
            check_eq("b2b_data",   32'(hs_a.out_data), 32'(k));
            check_eq("b2b_b_data", 32'(hs_b.out_data), 32'(k));
            tick();
            check_eq("b2b_ack", 32'(hs_a.ack_tgl), 32'(k % 2));
        end
        check_eq("b2b_ack_end", 32'(hs_a.ack_tgl),    32'd0);
        check_eq("b2b_cnt",     32'(hs_a.xfer_count), 32'd4);
        check_eq("b2b_err",     32'(hs_a.proto_err),  32'd0);
        check_eq("b2b_b_cnt",   32'(hs_b.xfer_count), 32'd0);
        req_data = 8'h05;
        req_tgl  = ~req_tgl;
        wait_valid("wrap_valid");
        tick();
        check_eq("wrap_a_cnt", 32'(hs_a.xfer_count), 32'd5);
        check_eq("wrap_b_cnt", 32'(hs_b.xfer_count), 32'd1);
        check_eq("wrap_b_ack", 32'(hs_b.ack_tgl),    32'd1);

        // Protocol violation: second toggle while VALID
        do_reset(1'b0);
        out_ready = 1'b0;
        req_data  = 8'h11;
        req_tgl   = 1'b1;
        wait_valid("viol_valid");
        check_eq("viol_err_pre", 32'(hs_a.proto_err), 32'd0);
        req_data = 8'h22;
        req_tgl  = 1'b0;
        repeat (3) tick();
        check_eq("viol_err",   32'(hs_a.proto_err), 32'd1);
        check_eq("viol_data",  32'(hs_a.out_data),  32'h11);
        check_eq("viol_valid_held", 32'(hs_a.out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check_eq("viol_ack", 32'(hs_a.ack_tgl), 32'd1);
        repeat (4) tick();
        check_eq("viol_no_2nd", 32'(hs_a.out_valid),  32'd0);
        check_eq("viol_cnt",    32'(hs_a.xfer_count), 32'd1);
        req_data = 8'h33;
        req_tgl  = 1'b1;
        wait_valid("viol_next_valid");
        check_eq("viol_next_data", 32'(hs_a.out_data), 32'h33);
        tick();
        check_eq("viol_next_cnt",  32'(hs_a.xfer_count), 32'd2);
        check_eq("viol_next_ack",  32'(hs_a.ack_tgl),    32'd0);
        check_eq("viol_sticky",    32'(hs_a.proto_err),  32'd1);

        // Reset while a word is pending
        out_ready = 1'b0;
        req_data  = 8'h44;
        req_tgl   = 1'b0;
        wait_valid("mid_valid");
        rst     = 1'b1;
        req_tgl = 1'b0;
        tick();
        check_eq("mid_valid_drop", 32'(hs_a.out_valid),  32'd0);
        check_eq("mid_ack",        32'(hs_a.ack_tgl),    32'd0);
        check_eq("mid_err_clr",    32'(hs_a.proto_err),  32'd0);
        check_eq("mid_cnt",        32'(hs_a.xfer_count), 32'd0);
        check_eq("mid_b_valid",    32'(hs_b.out_valid),  32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check_eq("mid_quiet", 32'(hs_a.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule : tb_tgl_hs_responder

// File: doc/tgl_hs_responder.md
# tgl_hs_responder

Responder end of the two-phase (toggle) handshake whose initiator drives its request with a T flip-flop: every toggle of `req_tgl` announces one new word on `req_data`. The block detects each toggle and captures the word. It presents the word downstream on a valid/ready port and answers the initiator by toggling `ack_tgl` once the word is consumed. It sits between a toggle-signalling producer and any valid/ready consumer, and flags protocol violations.

## Interface
- `DW`, 8: width of `req_data` / `out_data`.
- `SYNC_STAGES`, 2: register stages on `req_tgl` before edge detection; legal range 1..4.
- `CW`, 16: width of `xfer_count`.

- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `req_tgl`  in  1  request level from the initiator; each change = one new word.
- `req_data`  in  DW  word from the initiator; held stable from its toggle until our `ack_tgl` answers.
- `ack_tgl`  out  1  acknowledge level; toggles exactly once per consumed word.
- `out_valid`  out  1  captured word available.
- `out_data`  out  DW  captured word, stable while `out_valid`.
- `out_ready`  in  1  downstream accepts when high together with `out_valid`.
- `busy`  out  1  high in VALID state.
- `proto_err`  out  1  sticky: a request toggle arrived while a word was pending.
- `xfer_count`  out  CW  number of words consumed, wraps modulo 2^CW.

## Operation
- Synchronizer: `req_s` = `req_tgl` delayed by `SYNC_STAGES` registers. `req_last` holds the last consumed request level. Event when `req_s != req_last`.
- FSM, 2 states:
  - IDLE: on event: `out_data <= req_data`, `req_last <= req_s`, `out_valid <= 1`, go VALID. No event: hold.
  - VALID: when `out_valid & out_ready`: `out_valid <= 0`, `ack_tgl <= ~ack_tgl`, `xfer_count <= xfer_count + 1`, go IDLE.
  - VALID, event seen (second toggle before ack): `proto_err <= 1`, `req_last <= req_s`. That event is discarded and its data is not captured. The pending word and handshake continue unaffected.
- Word accepted and violating event in the same cycle: both actions occur; the block returns to IDLE with the violating toggle consumed, so it does not produce a second word.
- `out_data` changes only on capture in IDLE.
- `xfer_count` wraps from 2^CW-1 to 0 silently.
- `proto_err` clears only on `rst`.

## Timing
- Reset values (after any edge with `rst`=1): `ack_tgl`=0, `out_valid`=0, `out_data`=0, `busy`=0, `proto_err`=0, `xfer_count`=0, all sync stages=0, `req_last`=0, state IDLE.
- Capture latency: `req_tgl` changes before edge n, so `out_valid`=1 after edge n+SYNC_STAGES. `req_data` is sampled at that same edge.
- Ack latency: handshake at edge m, so `ack_tgl` flips and `out_valid` falls after edge m (0 extra cycles).
- Throughput: IDLE can detect a new event in the cycle after edge m. The minimum period per word is bounded by the initiator's round trip, with 1 cycle responder overhead plus `SYNC_STAGES`.
- `out_valid` never drops without a handshake, except on `rst`.
- Reset mid-operation: the pending word is dropped and no ack toggle is issued. The initiator must be reset in the same cycle so both levels restart at 0.

## Structure
- Shared package `tgl_hs_pkg`: state enum (`TH_IDLE`, `TH_VALID`) and the `SYNC_STAGES` legal-range constants, reused by the matching initiator.
- One sub-module `tgl_sync`: parameterised N-stage shift synchronizer with sync reset, instantiated once for `req_tgl`.

## Test plan
- Reset: hold `rst` 3 cycles with `req_tgl`=1 → all outputs 0 after the first reset edge; after release, 1 event is detected (`req_s`=1 ≠ `req_last`=0).
- Single word, SYNC_STAGES=2: toggle `req_tgl` 0→1 with `req_data`=8'hA5 before edge 10, `out_ready`=1 → `out_valid`=1 and `out_data`=A5 after edge 12. `ack_tgl`=1 and `out_valid`=0 after edge 13. `xfer_count`=1.
- Backpressure: `out_ready`=0 for 5 cycles → `out_valid` and `out_data` held and `ack_tgl` unchanged. The ack toggles on the edge `out_ready` rises.
- Back-to-back: the initiator toggles again on seeing each ack, 4 words 01,02,03,04 → 4 outputs in order, `ack_tgl` ends at 0, `xfer_count`=4, `proto_err`=0.
- Violation: second toggle while VALID with `out_ready`=0 → `proto_err`=1 sticky, only 1 word delivered, and the next legal toggle is captured normally.
- Wrap and reset mid-op: CW=2, 5 words → `xfer_count`=1. Assert `rst` while VALID → `out_valid`=0 next cycle and no ack toggle.
